// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-item vending controller.
//   state_t     : controller states
//   COIN5_CR    : credit value of a 5-unit coin
//   COIN10_CR   : credit value of a 10-unit coin
//   credit_add  : credit contributed by one cycle's coin pulses
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam int unsigned COIN5_CR  = 1;
    localparam int unsigned COIN10_CR = 2;

    // Both coins in one cycle add 3 credits.
    function automatic logic [1:0] credit_add(input logic coin5, input logic coin10);
        credit_add = (coin5  ? 2'(COIN5_CR)  : 2'd0)
                   + (coin10 ? 2'(COIN10_CR) : 2'd0);
    endfunction

endpackage

// File: rtl/vend_moore_multi_if.sv
// Front-end/dispenser bus of the vending controller.
//   master: coin/keypad side (drives coins, selection, cancel, restock)
//   slave : controller side (drives vend, change5, coin_reject, credit,
//           sold_out, busy)
interface vend_moore_multi_if #(
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned MAX_CREDIT = 6
);
    localparam int unsigned IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam int unsigned CW = $clog2(MAX_CREDIT + 1);

    logic                 coin5;
    logic                 coin10;
    logic                 sel_valid;
    logic [IW-1:0]        sel_idx;
    logic                 cancel;
    logic                 restock;
    logic [NUM_ITEMS-1:0] vend;
    logic                 change5;
    logic                 coin_reject;
    logic [CW-1:0]        credit;
    logic [NUM_ITEMS-1:0] sold_out;
    logic                 busy;

    modport master (
        output coin5, coin10, sel_valid, sel_idx, cancel, restock,
        input  vend, change5, coin_reject, credit, sold_out, busy
    );

    modport slave (
        input  coin5, coin10, sel_valid, sel_idx, cancel, restock,
        output vend, change5, coin_reject, credit, sold_out, busy
    );

endinterface

// File: rtl/vend_stock.sv
// Per-item stock counters with saturating decrement and bulk reload.
//   clk, reset_n : clock, async active-low reset (loads STOCK_INIT)
//   dec_en_i     : take one unit of item dec_idx_i
//   dec_idx_i    : item to decrement
//   restock_i    : reload every counter to STOCK_INIT
//   sold_out_o   : bit i set when counter i is zero
module vend_stock #(
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned STOCK_INIT = 2,
    parameter int unsigned IW         = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 dec_en_i,
    input  logic [IW-1:0]        dec_idx_i,
    input  logic                 restock_i,
    output logic [NUM_ITEMS-1:0] sold_out_o
);
    localparam int unsigned SW = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

    logic [SW-1:0] stock_q [NUM_ITEMS];

    // Reload has priority; counters never wrap below zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= SW'(STOCK_INIT);
            end
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (restock_i) begin
                    stock_q[i] <= SW'(STOCK_INIT);
                end else if (dec_en_i && (dec_idx_i == IW'(i)) && (stock_q[i] != '0)) begin
                    stock_q[i] <= stock_q[i] - SW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            sold_out_o[i] = (stock_q[i] == '0);
        end
    end

endmodule

// File: rtl/vend_moore_multi.sv
// Multi-item Moore vending controller: coin credit, item selection,
// one-cycle vend pulse and serial 5-unit change/refund.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : coins/selection/cancel/restock in;
//                  vend/change5/coin_reject/credit/sold_out/busy out
module vend_moore_multi
    import vend_pkg::*;
#(
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned PRICE      = 3,
    parameter int unsigned MAX_CREDIT = 6,
    parameter int unsigned STOCK_INIT = 2,
    parameter int unsigned AUTO_VEND  = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    vend_moore_multi_if.slave bus
);
    localparam int unsigned IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam int unsigned CW = $clog2(MAX_CREDIT + 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        credit_q, credit_d;
    logic [IW-1:0]        item_q, item_d;
    logic                 coin_reject_q, coin_reject_d;
    logic [NUM_ITEMS-1:0] sold_out;
    logic                 sel_in_stock;
    logic                 sale;
    logic                 taken;
    logic                 coin_any;
    logic [CW+1:0]        credit_sum;
    logic                 restock_en;

    // Selected index is in range and that item still has stock.
    always_comb begin
        sel_in_stock = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if ((bus.sel_idx == IW'(i)) && !sold_out[i]) begin
                sel_in_stock = 1'b1;
            end
        end
    end

    // Next-state, credit and coin-acceptance decision.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        item_d        = item_q;
        coin_reject_d = 1'b0;
        sale          = 1'b0;
        taken         = 1'b0;
        coin_any      = bus.coin5 | bus.coin10;
        credit_sum    = (CW+2)'(credit_q) + (CW+2)'(credit_add(bus.coin5, bus.coin10));

        case (state_q)
            IDLE, COLLECT: begin
                // Cancel wins over selection and auto-vend.
                if ((state_q == COLLECT) && bus.cancel) begin
                    state_d = CHANGE;
                    taken   = 1'b1;
                end else if (AUTO_VEND != 0) begin
                    if ((state_q == COLLECT) && (credit_q >= CW'(PRICE)) && !sold_out[0]) begin
                        sale   = 1'b1;
                        item_d = '0;
                    end
                end else if (bus.sel_valid && (credit_q >= CW'(PRICE)) && sel_in_stock) begin
                    sale   = 1'b1;
                    item_d = bus.sel_idx;
                end

                if (sale) begin
                    taken    = 1'b1;
                    credit_d = credit_q - CW'(PRICE);
                    state_d  = VEND;
                end

                // A cycle's coins are taken all-or-nothing.
                if (coin_any) begin
                    if (taken || (credit_sum > (CW+2)'(MAX_CREDIT))) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = CW'(credit_sum);
                        state_d  = COLLECT;
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_any;
                state_d       = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                coin_reject_d = coin_any;
                credit_d      = credit_q - CW'(1);
                if (credit_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            item_q        <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            item_q        <= item_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign restock_en = bus.restock && (state_q == IDLE);

    vend_stock #(
        .NUM_ITEMS  (NUM_ITEMS),
        .STOCK_INIT (STOCK_INIT),
        .IW         (IW)
    ) u_stock (
        .clk        (clk),
        .reset_n    (reset_n),
        .dec_en_i   (sale),
        .dec_idx_i  (item_d),
        .restock_i  (restock_en),
        .sold_out_o (sold_out)
    );

    // Outputs decode from registers only.
    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_vend
        assign bus.vend[g] = (state_q == VEND) && (item_q == IW'(g));
    end

    assign bus.change5     = (state_q == CHANGE);
    assign bus.busy        = (state_q == VEND) || (state_q == CHANGE);
    assign bus.credit      = credit_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.sold_out    = sold_out;

endmodule

// File: tb/tb_vend_moore_multi.sv
// Bench for vend_moore_multi: a manual-select instance (4 items) and an
// auto-vend instance (1 item), both checked every cycle against a
// transaction-level model, plus literal checks on directed scenarios.
module tb_vend_moore_multi;

    localparam int PRICE = 3;
    localparam int MAXC  = 6;
    localparam int SINIT = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stimulus per instance (0 = manual select, 1 = auto vend).
    logic in_c5 [2];
    logic in_c10[2];
    logic in_sel[2];
    int   in_idx[2];
    logic in_can[2];
    logic in_rs [2];

    vend_moore_multi_if #(.NUM_ITEMS(4), .MAX_CREDIT(MAXC)) ifa ();
    vend_moore_multi_if #(.NUM_ITEMS(1), .MAX_CREDIT(MAXC)) ifb ();

    assign ifa.coin5     = in_c5[0];
    assign ifa.coin10    = in_c10[0];
    assign ifa.sel_valid = in_sel[0];
    assign ifa.sel_idx   = 2'(in_idx[0]);
    assign ifa.cancel    = in_can[0];
    assign ifa.restock   = in_rs[0];
    assign ifb.coin5     = in_c5[1];
    assign ifb.coin10    = in_c10[1];
    assign ifb.sel_valid = in_sel[1];
    assign ifb.sel_idx   = 1'(in_idx[1]);
    assign ifb.cancel    = in_can[1];
    assign ifb.restock   = in_rs[1];

    vend_moore_multi #(
        .NUM_ITEMS(4), .PRICE(PRICE), .MAX_CREDIT(MAXC), .STOCK_INIT(SINIT), .AUTO_VEND(0)
    ) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));

    vend_moore_multi #(
        .NUM_ITEMS(1), .PRICE(PRICE), .MAX_CREDIT(MAXC), .STOCK_INIT(SINIT), .AUTO_VEND(1)
    ) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

    logic [3:0] o_vend[2];
    logic       o_ch  [2];
    logic       o_rej [2];
    logic       o_busy[2];
    logic [2:0] o_cr  [2];
    logic [3:0] o_so  [2];

    assign o_vend[0] = ifa.vend;
    assign o_vend[1] = {3'b000, ifb.vend};
    assign o_ch[0]   = ifa.change5;
    assign o_ch[1]   = ifb.change5;
    assign o_rej[0]  = ifa.coin_reject;
    assign o_rej[1]  = ifb.coin_reject;
    assign o_busy[0] = ifa.busy;
    assign o_busy[1] = ifb.busy;
    assign o_cr[0]   = ifa.credit;
    assign o_cr[1]   = ifb.credit;
    assign o_so[0]   = ifa.sold_out;
    assign o_so[1]   = {3'b000, ifb.sold_out};

    // Model: credit, stock levels, and the payout still owed
    // (a pending vend pulse, then refund coins one per cycle).
    int m_credit[2];
    int m_stock [2][4];
    int m_vend  [2];
    int m_refund[2];
    int m_rej   [2];

    function automatic int ni(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int exp_vend(input int i);
        return (m_vend[i] >= 0) ? (1 << m_vend[i]) : 0;
    endfunction

    function automatic int exp_change(input int i);
        return (m_vend[i] < 0 && m_refund[i] > 0) ? 1 : 0;
    endfunction

    function automatic int exp_busy(input int i);
        return (m_vend[i] >= 0 || m_refund[i] > 0) ? 1 : 0;
    endfunction

    function automatic int exp_so(input int i);
        int so;
        so = 0;
        for (int k = 0; k < ni(i); k++) begin
            if (m_stock[i][k] == 0) so = so | (1 << k);
        end
        return so;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_credit[i] = 0;
            m_vend[i]   = -1;
            m_refund[i] = 0;
            m_rej[i]    = 0;
            for (int k = 0; k < 4; k++) m_stock[i][k] = SINIT;
        end
    endtask

    task automatic m_sell(input int i, input int k);
        m_credit[i]   = m_credit[i] - PRICE;
        m_stock[i][k] = m_stock[i][k] - 1;
        m_vend[i]     = k;
        m_refund[i]   = m_credit[i];
    endtask

    task automatic m_step(input int i);
        int coins;
        int add;
        int took;
        int idle_now;
        coins = (in_c5[i] || in_c10[i]) ? 1 : 0;
        add   = (in_c5[i] ? 1 : 0) + (in_c10[i] ? 2 : 0);
        if (m_vend[i] >= 0) begin
            m_vend[i] = -1;
            m_rej[i]  = coins;
        end else if (m_refund[i] > 0) begin
            m_refund[i] = m_refund[i] - 1;
            m_credit[i] = m_credit[i] - 1;
            m_rej[i]    = coins;
        end else begin
            took     = 0;
            idle_now = (m_credit[i] == 0) ? 1 : 0;
            if (in_can[i] && idle_now == 0) begin
                m_refund[i] = m_credit[i];
                took = 1;
            end else if (i == 1) begin
                if (m_credit[i] >= PRICE && m_stock[i][0] > 0) begin
                    m_sell(i, 0);
                    took = 1;
                end
            end else if (in_sel[i] && in_idx[i] < ni(i) && m_credit[i] >= PRICE
                         && m_stock[i][in_idx[i]] > 0) begin
                m_sell(i, in_idx[i]);
                took = 1;
            end
            if (in_rs[i] && idle_now != 0) begin
                for (int k = 0; k < 4; k++) m_stock[i][k] = SINIT;
            end
            m_rej[i] = 0;
            if (coins != 0) begin
                if (took != 0 || m_credit[i] + add > MAXC) m_rej[i] = 1;
                else m_credit[i] = m_credit[i] + add;
            end
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_reset();
        else for (int i = 0; i < 2; i++) m_step(i);
    end

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                chk("m_vend",   i, int'(o_vend[i]), exp_vend(i));
                chk("m_change", i, int'(o_ch[i]),   exp_change(i));
                chk("m_busy",   i, int'(o_busy[i]), exp_busy(i));
                chk("m_credit", i, int'(o_cr[i]),   m_credit[i]);
                chk("m_reject", i, int'(o_rej[i]),  m_rej[i]);
                chk("m_soldout",i, int'(o_so[i]),   exp_so(i));
            end
        end
    end

    task automatic clr(input int i);
        in_c5[i] = 1'b0; in_c10[i] = 1'b0; in_sel[i] = 1'b0;
        in_idx[i] = 0;   in_can[i] = 1'b0; in_rs[i]  = 1'b0;
    endtask

    // One cycle of stimulus on instance i, returns at the next negedge.
    task automatic drive(input int i, input logic c5, input logic c10, input logic sv,
                         input int idx, input logic can, input logic rs);
        in_c5[i] = c5; in_c10[i] = c10; in_sel[i] = sv;
        in_idx[i] = idx; in_can[i] = can; in_rs[i] = rs;
        @(negedge clk);
        clr(i);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        clr(0);
        clr(1);
        reset_n = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_credit", 0, int'(o_cr[0]), 0);
        chk("rst_busy",   0, int'(o_busy[0]), 0);
        chk("rst_soldout",0, int'(o_so[0]), 0);

        // 1: 4 credits, buy item 1, one change pulse
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("t1_credit4", 0, int'(o_cr[0]), 4);
        drive(0, 0, 0, 1, 1, 0, 0);
        chk("t1_vend", 0, int'(o_vend[0]), 4'b0010);
        idle(1);
        chk("t1_change", 0, int'(o_ch[0]), 1);
        chk("t1_novend", 0, int'(o_vend[0]), 0);
        idle(1);
        chk("t1_change_done", 0, int'(o_ch[0]), 0);
        chk("t1_credit0", 0, int'(o_cr[0]), 0);
        chk("t1_idle", 0, int'(o_busy[0]), 0);
        chk("t1_soldout", 0, int'(o_so[0]), 0);

        // 2: cancel refunds 2 credits
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("t2_ch1", 0, int'(o_ch[0]) + 2 * int'(o_vend[0]), 1);
        idle(1);
        chk("t2_ch2", 0, int'(o_ch[0]) + 2 * int'(o_vend[0]), 1);
        idle(1);
        chk("t2_ch_end", 0, int'(o_ch[0]), 0);
        chk("t2_credit", 0, int'(o_cr[0]), 0);

        // 3: exhaust item 0, then refused selection, then item 2
        for (int n = 0; n < 2; n++) begin
            drive(0, 0, 1, 0, 0, 0, 0);
            drive(0, 1, 0, 0, 0, 0, 0);
            drive(0, 0, 0, 1, 0, 0, 0);
            chk("t3_vend0", 0, int'(o_vend[0]), 4'b0001);
            idle(1);
        end
        chk("t3_soldout0", 0, int'(o_so[0]), 4'b0001);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("t3_refused", 0, int'(o_vend[0]), 0);
        chk("t3_credit3", 0, int'(o_cr[0]), 3);
        drive(0, 0, 0, 1, 2, 0, 0);
        chk("t3_vend2", 0, int'(o_vend[0]), 4'b0100);
        idle(1);

        // 4: overflow reject and reject while busy
        repeat (3) drive(0, 0, 1, 0, 0, 0, 0);
        chk("t4_credit6", 0, int'(o_cr[0]), 6);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("t4_reject", 0, int'(o_rej[0]), 1);
        chk("t4_credit_kept", 0, int'(o_cr[0]), 6);
        idle(1);
        chk("t4_reject_clr", 0, int'(o_rej[0]), 0);
        drive(0, 0, 0, 1, 3, 0, 0);
        chk("t4_vend3", 0, int'(o_vend[0]), 4'b1000);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("t4_busy_reject", 0, int'(o_rej[0]), 1);
        chk("t4_credit_busy", 0, int'(o_cr[0]), 3);
        idle(3);
        chk("t4_drained", 0, int'(o_cr[0]), 0);

        // 5: auto vend on the single-item instance
        drive(1, 0, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        idle(1);
        chk("t5_autovend", 1, int'(o_vend[1]), 1);
        chk("t5_credit0", 1, int'(o_cr[1]), 0);
        idle(1);
        chk("t5_nochange", 1, int'(o_ch[1]), 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        idle(1);
        chk("t5_autovend2", 1, int'(o_vend[1]), 1);
        idle(1);
        chk("t5_change", 1, int'(o_ch[1]), 1);
        idle(1);
        chk("t5_change_end", 1, int'(o_ch[1]), 0);
        chk("t5_soldout", 1, int'(o_so[1]), 1);

        // 6: async reset mid-refund
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("t6_in_change", 0, int'(o_ch[0]), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_credit", 0, int'(o_cr[0]), 0);
        chk("t6_rst_change", 0, int'(o_ch[0]), 0);
        chk("t6_rst_busy",   0, int'(o_busy[0]), 0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        chk("t6_stock_back", 0, int'(o_so[0]), 0);
        chk("t6_stock_back", 1, int'(o_so[1]), 0);
        chk("t6_idle", 0, int'(o_busy[0]), 0);

        // Random traffic on both instances, checked by the model.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                in_c5[i]  = ($urandom_range(99, 0) < 30);
                in_c10[i] = ($urandom_range(99, 0) < 20);
                in_sel[i] = ($urandom_range(99, 0) < 25);
                in_idx[i] = (i == 0) ? int'($urandom_range(3, 0)) : int'($urandom_range(1, 0));
                in_can[i] = ($urandom_range(99, 0) < 4);
                in_rs[i]  = ($urandom_range(99, 0) < 4);
            end
            @(negedge clk);
        end
        clr(0);
        clr(1);
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
